// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [1:0] slot_t;

  localparam int NUM_CH = 4;

  // Width of the frame counter; a word spans WIDTH frames.
  function automatic int frame_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/chan_shift.sv
// Per-channel MSB-first shift register with shift enable and synchronous clear.
// Latency: 1 cycle; word presents the post-update contents. No backpressure.
// Clear and shift in the same cycle restarts the word with din as its first bit.
module chan_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] sr;

  always_comb begin
    word = sr;
    if (clr) begin
      word = shift_en ? {{(WIDTH-1){1'b0}}, din} : '0;
    end else if (shift_en) begin
      word = {sr[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= word;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: frame-sync alignment, per-slot steering, parallel words.
// Latency: valid one cycle after the last (channel 3) bit is sampled; all outputs registered.
// Backpressure: none; en paces input. Optional err_cnt port via TDM_DEMUX_ERRCNT_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             valid,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int FW = frame_bits(WIDTH);
  localparam logic [FW-1:0] FRAME_LAST = FW'(WIDTH - 1);

  state_t           state;
  slot_t            slot;
  logic [FW-1:0]    frame;
  logic [WIDTH-1:0] word [NUM_CH];
  logic [NUM_CH-1:0] shift_en;
  logic             at_boundary;
  logic             accept;
  logic             restart;
  logic             misaligned;
  logic             word_done;

  always_comb begin
    at_boundary = (slot == 2'd0) && (frame == '0);
    accept      = en && ((state == LOCK) || sync);
    // A sync that starts a new word: first lock, or a realignment after error.
    restart     = en && sync && ((state == HUNT) || !at_boundary);
    misaligned  = en && sync && (state == LOCK) && !at_boundary;
    word_done   = accept && !restart && (slot == 2'd3) && (frame == FRAME_LAST);
    shift_en    = '0;
    if (accept) begin
      shift_en[restart ? 2'd0 : slot] = 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    chan_shift #(.WIDTH(WIDTH)) u_chan_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (restart),
      .shift_en (shift_en[ch]),
      .din      (din),
      .word     (word[ch])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      frame    <= '0;
      q0       <= '0;
      q1       <= '0;
      q2       <= '0;
      q3       <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
      if (accept) begin
        if (restart) begin
          state    <= LOCK;
          locked   <= 1'b1;
          slot     <= 2'd1;
          frame    <= '0;
          sync_err <= misaligned;
        end else begin
          slot <= slot + 2'd1;
          if (slot == 2'd3) begin
            frame <= (frame == FRAME_LAST) ? '0 : frame + FW'(1);
          end
          if (word_done) begin
            q0    <= word[0];
            q1    <= word[1];
            q2    <= word[2];
            q3    <= word[3];
            valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (misaligned && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
